layer_mem_arbiter: RTL and testbench
====================================

// Module: layer_mem_arbiter
// PURPOSE
//  Shares the single layer-memory port (cwr/crd/csel/caddr_*/cdata_*) among NREQ requesters:
//  the conv writer (L0), the max-pool engine (reads L0, writes L1) and a host/debug readback port.
//  Round-robin arbitration, optional burst lock, in-order read-return routing.
//  Sits between the compute engines and the testbench-side L0/L1 memories.
// PARAMETERS
//  NREQ      3   number of requesters
//  AW        12  layer-memory address width
//  DW        13  layer-memory data width
//  RD_LAT    1   edges from the edge raising crd to the edge sampling cdata_rd (>=1)
//  LOCK_MAX  8   max consecutive locked grants before forced release
// PORTS
//  clk       in   1        clock; all logic on rising edge
//  reset     in   1        synchronous, active-low; reset==0 at an edge clears all state
//  req       in   NREQ     access request per requester; held until gnt
//  wr        in   NREQ     1=write, 0=read
//  sel       in   NREQ     layer select, 0=L0, 1=L1
//  lock      in   NREQ     keep ownership after this access
//  addr      in   NREQ*AW  packed per-requester address; index i at [i*AW +: AW]
//  wdata     in   NREQ*DW  packed per-requester write data
//  gnt       out  NREQ     one-hot, 1-cycle pulse: access issued to memory this cycle
//  rvalid    out  NREQ     one-hot, 1-cycle pulse: rdata belongs to this requester
//  rdata     out  DW       read-return data, shared
//  cwr       out  1        memory write strobe
//  crd       out  1        memory read strobe
//  csel      out  1        memory layer select
//  caddr_wr  out  AW       memory write address
//  caddr_rd  out  AW       memory read address
//  cdata_wr  out  DW       memory write data
//  cdata_rd  in   DW       memory read data
// BEHAVIOUR
//  - Reset: every output, the RR pointer, the lock counter and the read-tag pipe are 0; FSM=ARB.
//  - Issue timing: req sampled at edge E. The winner gets gnt, strobe, csel, address and data,
//    all registered, during the cycle after E. At most one access per cycle; back-to-back is allowed.
//  - A requester whose gnt is high drops or changes req/addr at the next edge. A new access needs req high at that edge.
//  - Idle cycle (no winner): gnt=0, cwr=crd=0. caddr_*, cdata_wr and csel hold their last values.
//  - Write grant: cwr=1, crd=0, caddr_wr=addr[i], cdata_wr=wdata[i], csel=sel[i].
//  - Read grant: crd=1, cwr=0, caddr_rd=addr[i], csel=sel[i].
//  - Read return: owner index enters an RD_LAT-deep tag pipe. cdata_rd is sampled RD_LAT edges
//    after the edge that raised crd. rdata/rvalid[owner] are high in the following cycle.
//    With RD_LAT=1: crd in cycle N, rvalid in N+1. Returns are strictly in issue order.
//  - FSM ARB: round-robin search from ptr over req. After a grant to i, ptr=(i+1)%NREQ.
//    If lock[i] was 1 at the grant, go to LOCKED(owner=i) with lock_cnt=1.
//  - FSM LOCKED: only the owner is eligible. Stay while req[owner]&lock[owner] and lock_cnt<LOCK_MAX;
//    each owner grant increments lock_cnt.
//    A grant with lock=0 returns to ARB after issuing.
//    req[owner]=0 at an edge returns to ARB with no grant that cycle.
//    When lock_cnt==LOCK_MAX the FSM returns to ARB. The next arbitration excludes the owner for one round when others request.
//  - Write-then-read to the same address from any requesters: memory sees them in grant order.
//    The arbiter adds no forwarding.
//  - Reset mid-operation: in-flight read tags are discarded and no rvalid follows.
//    Requests pending at reset must be re-presented.
//  - Invariants: cwr&crd never 1; |gnt ⇔ cwr|crd; gnt and rvalid are each at most one-hot.
// STRUCTURE
//  - Package layer_mem_pkg: AW, DW, NREQ; REQ_CONV=0, REQ_POOL=1, REQ_HOST=2; LAYER_L0=0, LAYER_L1=1;
//    FSM state enum {ARB, LOCKED}.
//  - Sub-module rr_pick: combinational round-robin one-hot picker (req, ptr, mask -> onehot, idx).
//  - Top holds the FSM, lock counter, output registers and the read-tag shift pipe.
// TESTING
//  1 Single read: L0[0x040]=0x0A5; req[1]=1 wr=0 sel=0 addr=0x040
//    -> next cycle gnt[1]=1 crd=1 csel=0 caddr_rd=0x040; following cycle rvalid[1]=1 rdata=0x0A5.
//  2 Write: req[0]=1 wr=1 sel=1 addr=0x3FF wdata=0x1FF0
//    -> one cycle cwr=1 csel=1 caddr_wr=0x3FF cdata_wr=0x1FF0 crd=0; L1[0x3FF]==0x1FF0.
//  3 Fairness: all three requesters write continuously from reset -> gnt order 0,1,2,0,1,2; one grant per cycle.
//  4 Lock burst: req[1] lock=1 for 4 reads, lock=0 on the 4th, req[0] pending -> gnt[1] x4 then gnt[0].
//    With lock held 20 cycles -> gnt[0] immediately after the 8th gnt[1].
//  5 Reset mid-read: reset=0 at the edge after crd cycle -> no rvalid ever appears; all outputs 0 next cycle.
//  6 Idle: req=0 for 50 cycles -> gnt=rvalid=0, cwr=crd=0 throughout.

Source files
------------

// File: rtl/layer_mem_arbiter_pkg.sv
// Shared constants, types and small helpers for the layer-memory arbiter.
package layer_mem_pkg;

   localparam int NREQ = 3;
   localparam int AW   = 12;
   localparam int DW   = 13;
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam int REQ_CONV = 0;
   localparam int REQ_POOL = 1;
   localparam int REQ_HOST = 2;

   localparam logic LAYER_L0 = 1'b0;
   localparam logic LAYER_L1 = 1'b1;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef logic [IW-1:0] req_idx_t;

   // Round-robin successor of a requester index, wrapping at NREQ.
   function automatic req_idx_t next_ptr(input req_idx_t i);
      return (i == req_idx_t'(NREQ - 1)) ? '0 : i + req_idx_t'(1);
   endfunction

   // Requester index to one-hot vector.
   function automatic logic [NREQ-1:0] idx_to_onehot(input req_idx_t i);
      logic [NREQ-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// Requester bundle plus the single layer-memory port. The slave side is the
// arbiter; the master side is whatever drives requests and models memory.
interface layer_mem_arbiter_if;
   import layer_mem_pkg::*;

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    wr;
   logic [NREQ-1:0]    sel;
   logic [NREQ-1:0]    lock;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   logic               cwr;
   logic               crd;
   logic               csel;
   logic [AW-1:0]      caddr_wr;
   logic [AW-1:0]      caddr_rd;
   logic [DW-1:0]      cdata_wr;
   logic [DW-1:0]      cdata_rd;

   modport master (
      output req, wr, sel, lock, addr, wdata, cdata_rd,
      input  gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
   );

   modport slave (
      input  req, wr, sel, lock, addr, wdata, cdata_rd,
      output gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
   );

endinterface

// File: rtl/layer_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_pick
   import layer_mem_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   input  req_idx_t        ptr,
   output logic [NREQ-1:0] onehot,
   output req_idx_t        idx,
   output logic            valid
);

   logic [NREQ-1:0] eligible;

   assign eligible = req & mask;

   // Walk the requesters starting at ptr and stop at the first eligible one.
   always_comb begin
      int       pos;
      req_idx_t cand;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = 0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos  = (int'(ptr) + k) % NREQ;
         cand = req_idx_t'(pos);
         if (!valid && eligible[cand]) begin
            valid        = 1'b1;
            idx          = cand;
            onehot       = '0;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares the single layer-memory port among the conv writer, the pool engine
// and the host readback port: round-robin arbitration with an optional burst
// lock, registered memory strobes and in-order read-return routing.
module layer_mem_arbiter
   import layer_mem_pkg::*;
#(
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 8
) (
   input logic                clk,
   input logic                reset,
   layer_mem_arbiter_if.slave bus
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_t      state;
   arb_state_t      state_nxt;
   req_idx_t        ptr;
   req_idx_t        ptr_nxt;
   req_idx_t        owner;
   req_idx_t        owner_nxt;
   logic [CW-1:0]   lock_cnt;
   logic [CW-1:0]   lock_cnt_nxt;
   logic [CW-1:0]   lock_cnt_inc;

   logic [NREQ-1:0] pick_mask;
   logic [NREQ-1:0] pick_onehot;
   req_idx_t        pick_idx;
   logic            pick_valid;
   logic            issue;
   logic            issue_wr;

   logic [AW-1:0]   addr_arr  [NREQ];
   logic [DW-1:0]   wdata_arr [NREQ];

   logic [RD_LAT-1:0]           tag_v;
   req_idx_t [RD_LAT-1:0]       tag_idx;

   // Unpack the flat per-requester address and write-data buses.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_arr[i]  = bus.addr[i*AW +: AW];
         wdata_arr[i] = bus.wdata[i*DW +: DW];
      end
   end

   // While locked only the owner may win; otherwise everybody competes.
   always_comb begin
      pick_mask = '1;
      if (state == LOCKED) begin
         pick_mask        = '0;
         pick_mask[owner] = 1'b1;
      end
   end

   rr_pick u_pick (
      .req    (bus.req),
      .mask   (pick_mask),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign lock_cnt_inc = lock_cnt + CW'(1);
   assign issue_wr     = bus.wr[pick_idx];

   // Next-state logic: decides whether an access issues this edge and how the
   // pointer, lock ownership and burst counter move. Leaving a capped burst
   // puts the pointer just past the owner, so the owner goes last next round.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      lock_cnt_nxt = lock_cnt;
      ptr_nxt      = ptr;
      issue        = 1'b0;
      case (state)
         ARB: begin
            if (pick_valid) begin
               issue   = 1'b1;
               ptr_nxt = next_ptr(pick_idx);
               if (bus.lock[pick_idx] && (LOCK_MAX > 1)) begin
                  state_nxt    = LOCKED;
                  owner_nxt    = pick_idx;
                  lock_cnt_nxt = CW'(1);
               end
            end
         end
         LOCKED: begin
            if (!pick_valid) begin
               state_nxt    = ARB;
               lock_cnt_nxt = '0;
            end else begin
               issue   = 1'b1;
               ptr_nxt = next_ptr(pick_idx);
               if (!bus.lock[owner] || (lock_cnt_inc >= CW'(LOCK_MAX))) begin
                  state_nxt    = ARB;
                  lock_cnt_nxt = '0;
               end else begin
                  lock_cnt_nxt = lock_cnt_inc;
               end
            end
         end
         default: begin
            state_nxt    = ARB;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ARB;
         ptr      <= '0;
         owner    <= '0;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   // Registered memory-port drive; address, data and layer select hold when idle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.gnt      <= '0;
         bus.cwr      <= 1'b0;
         bus.crd      <= 1'b0;
         bus.csel     <= 1'b0;
         bus.caddr_wr <= '0;
         bus.caddr_rd <= '0;
         bus.cdata_wr <= '0;
      end else begin
         bus.gnt <= issue ? pick_onehot : '0;
         bus.cwr <= issue & issue_wr;
         bus.crd <= issue & ~issue_wr;
         if (issue) begin
            bus.csel <= bus.sel[pick_idx];
            if (issue_wr) begin
               bus.caddr_wr <= addr_arr[pick_idx];
               bus.cdata_wr <= wdata_arr[pick_idx];
            end else begin
               bus.caddr_rd <= addr_arr[pick_idx];
            end
         end
      end
   end

   // Read tags ride an RD_LAT-deep pipe so returns are routed in issue order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_v      <= '0;
         tag_idx    <= '0;
         bus.rvalid <= '0;
         bus.rdata  <= '0;
      end else begin
         for (int k = RD_LAT - 1; k > 0; k--) begin
            tag_v[k]   <= tag_v[k-1];
            tag_idx[k] <= tag_idx[k-1];
         end
         tag_v[0]   <= issue & ~issue_wr;
         tag_idx[0] <= pick_idx;
         bus.rvalid <= '0;
         if (tag_v[RD_LAT-1]) begin
            bus.rvalid <= idx_to_onehot(tag_idx[RD_LAT-1]);
            bus.rdata  <= bus.cdata_rd;
         end
      end
   end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Self-checking bench for layer_mem_arbiter: table of single accesses, then
// fairness, lock-burst, reset-mid-read and idle sequences, with a read-return
// scoreboard and per-cycle protocol invariants.
module tb_layer_mem_arbiter;
   import layer_mem_pkg::*;

   typedef struct {
      int            idx;
      bit            wr;
      bit            sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [NREQ-1:0] onehot;
      logic [DW-1:0]   data;
   } sb_t;

   logic clk;
   logic reset;

   layer_mem_arbiter_if bus ();

   logic [AW-1:0] a_arr [NREQ];
   logic [DW-1:0] d_arr [NREQ];

   logic [DW-1:0] l0_mem  [4096];
   logic [DW-1:0] l1_mem  [4096];
   logic [DW-1:0] ref_l0  [4096];
   logic [DW-1:0] ref_l1  [4096];

   sb_t  sb [$];
   int   glog [$];
   int   errors;
   int   checks;
   int   rv_count;
   int   k;
   int   idle_bad;
   int   rv_snap;
   bit   done;
   vec_t vecs [8];

   layer_mem_arbiter #(.RD_LAT(1), .LOCK_MAX(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.addr     = {a_arr[2], a_arr[1], a_arr[0]};
   assign bus.wdata    = {d_arr[2], d_arr[1], d_arr[0]};
   assign bus.cdata_rd = bus.csel ? l1_mem[bus.caddr_rd] : l0_mem[bus.caddr_rd];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Layer memories: reload known contents on reset, write on cwr.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4096; i++) begin
            l0_mem[i] = '0;
            l1_mem[i] = '0;
         end
         l0_mem[12'h040] = 13'h00A5;
         l0_mem[12'hABC] = 13'h1234;
         for (int i = 0; i < 4; i++) l0_mem[12'h050 + i] = 13'h0300 + 13'(i);
      end else if (bus.cwr) begin
         if (bus.csel) l1_mem[bus.caddr_wr] = bus.cdata_wr;
         else          l0_mem[bus.caddr_wr] = bus.cdata_wr;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: protocol invariants, grant log and read-return scoreboard.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checkOutput("invariants",
                     {31'b0, !(bus.cwr && bus.crd) && ((|bus.gnt) == (bus.cwr | bus.crd))
                             && $onehot0(bus.gnt) && $onehot0(bus.rvalid)}, 32'd1);
         for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) glog.push_back(i);
         if (|bus.rvalid) begin
            rv_count++;
            if (sb.size() == 0) begin
               checkOutput("sb_unexpected_rvalid", {29'b0, bus.rvalid}, 32'd0);
            end else begin
               sb_t e;
               e = sb.pop_front();
               checkOutput("sb_rvalid", {29'b0, bus.rvalid}, {29'b0, e.onehot});
               checkOutput("sb_rdata", {19'b0, bus.rdata}, {19'b0, e.data});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic initRef();
      for (int i = 0; i < 4096; i++) begin
         ref_l0[i] = '0;
         ref_l1[i] = '0;
      end
      ref_l0[12'h040] = 13'h00A5;
      ref_l0[12'hABC] = 13'h1234;
      for (int i = 0; i < 4; i++) ref_l0[12'h050 + i] = 13'h0300 + 13'(i);
   endtask

   task automatic clearInputs();
      bus.req  = '0;
      bus.wr   = '0;
      bus.sel  = '0;
      bus.lock = '0;
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = '0;
         d_arr[i] = '0;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      clearInputs();
      initRef();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [NREQ-1:0] oh;
      oh = idx_to_onehot(req_idx_t'(v.idx));
      @(negedge clk);
      clearInputs();
      bus.req[v.idx] = 1'b1;
      bus.wr[v.idx]  = v.wr;
      bus.sel[v.idx] = v.sel;
      a_arr[v.idx]   = v.addr;
      d_arr[v.idx]   = v.wdata;
      if (v.wr) begin
         if (v.sel) ref_l1[v.addr] = v.wdata;
         else       ref_l0[v.addr] = v.wdata;
      end else begin
         sb.push_back('{oh, v.sel ? ref_l1[v.addr] : ref_l0[v.addr]});
      end
      @(negedge clk);
      checkOutput("gnt", {29'b0, bus.gnt}, {29'b0, oh});
      checkOutput("cwr", {31'b0, bus.cwr}, {31'b0, v.wr});
      checkOutput("crd", {31'b0, bus.crd}, {31'b0, !v.wr});
      checkOutput("csel", {31'b0, bus.csel}, {31'b0, v.sel});
      if (v.wr) begin
         checkOutput("caddr_wr", {20'b0, bus.caddr_wr}, {20'b0, v.addr});
         checkOutput("cdata_wr", {19'b0, bus.cdata_wr}, {19'b0, v.wdata});
      end else begin
         checkOutput("caddr_rd", {20'b0, bus.caddr_rd}, {20'b0, v.addr});
      end
      clearInputs();
      if (!v.wr) begin
         @(negedge clk);
         checkOutput("rvalid", {29'b0, bus.rvalid}, {29'b0, oh});
         checkOutput("rdata", {19'b0, bus.rdata}, {19'b0, v.exp_rdata});
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rv_count = 0;
      reset    = 1'b0;
      clearInputs();
      initRef();

      vecs[0] = '{1, 1'b0, 1'b0, 12'h040, 13'h0000, 13'h00A5};
      vecs[1] = '{0, 1'b1, 1'b1, 12'h3FF, 13'h1FF0, 13'h0000};
      vecs[2] = '{2, 1'b0, 1'b1, 12'h3FF, 13'h0000, 13'h1FF0};
      vecs[3] = '{2, 1'b1, 1'b0, 12'h040, 13'h0001, 13'h0000};
      vecs[4] = '{0, 1'b0, 1'b0, 12'h040, 13'h0000, 13'h0001};
      vecs[5] = '{1, 1'b1, 1'b1, 12'h000, 13'h1555, 13'h0000};
      vecs[6] = '{1, 1'b0, 1'b1, 12'h000, 13'h0000, 13'h1555};
      vecs[7] = '{0, 1'b0, 1'b0, 12'hABC, 13'h0000, 13'h1234};

      repeat (3) @(negedge clk);
      checkOutput("reset_strobes", {27'b0, bus.gnt, bus.cwr, bus.crd}, 32'd0);
      checkOutput("reset_rvalid", {29'b0, bus.rvalid}, 32'd0);
      checkOutput("reset_mem_port", {bus.csel, bus.caddr_wr, bus.caddr_rd} == '0 ? 32'd0 : 32'd1, 32'd0);
      checkOutput("reset_data", {bus.cdata_wr, bus.rdata} == '0 ? 32'd0 : 32'd1, 32'd0);
      reset = 1'b1;

      $display("[TB] single-access vector table");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
      repeat (2) @(negedge clk);
      checkOutput("l1_3ff", {19'b0, l1_mem[12'h3FF]}, 32'h1FF0);
      checkOutput("l0_040", {19'b0, l0_mem[12'h040]}, 32'h0001);

      $display("[TB] fairness from reset");
      doReset();
      glog.delete();
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = 12'h100 + 12'(i);
         d_arr[i] = 13'h0010 + 13'(i);
      end
      bus.req = '1;
      bus.wr  = '1;
      repeat (6) @(negedge clk);
      clearInputs();
      @(negedge clk);
      checkOutput("rr_count", glog.size(), 32'd6);
      for (int i = 0; i < 6; i++)
         checkOutput("rr_order", (i < glog.size()) ? glog[i] : -1, i % 3);

      $display("[TB] lock burst released by lock=0");
      doReset();
      glog.delete();
      @(negedge clk);
      bus.req[1]  = 1'b1;
      bus.lock[1] = 1'b1;
      a_arr[1]    = 12'h050;
      sb.push_back('{3'b010, ref_l0[12'h050]});
      k    = 0;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (bus.gnt[0]) begin
            bus.req[0] = 1'b0;
            done       = 1'b1;
         end
         if (bus.gnt[1]) begin
            k++;
            if (k == 1) begin
               bus.req[0] = 1'b1;
               bus.wr[0]  = 1'b1;
               bus.sel[0] = 1'b1;
               a_arr[0]   = 12'h010;
               d_arr[0]   = 13'h0111;
               ref_l1[12'h010] = 13'h0111;
            end
            if (k < 4) begin
               a_arr[1]    = 12'h050 + 12'(k);
               bus.lock[1] = (k < 3);
               sb.push_back('{3'b010, ref_l0[12'h050 + k]});
            end else begin
               bus.req[1]  = 1'b0;
               bus.lock[1] = 1'b0;
            end
         end
      end
      checkOutput("lock_done", {31'b0, done}, 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("lock_count", glog.size(), 32'd5);
      for (int i = 0; i < 5; i++)
         checkOutput("lock_order", (i < glog.size()) ? glog[i] : -1, (i < 4) ? 1 : 0);

      $display("[TB] lock burst capped at LOCK_MAX");
      doReset();
      glog.delete();
      @(negedge clk);
      bus.req[1]  = 1'b1;
      bus.lock[1] = 1'b1;
      bus.wr[1]   = 1'b1;
      a_arr[1]    = 12'h020;
      d_arr[1]    = 13'h00AA;
      done        = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (bus.gnt[0]) begin
            clearInputs();
            done = 1'b1;
         end else if (bus.gnt[1]) begin
            bus.req[0] = 1'b1;
            bus.wr[0]  = 1'b1;
            bus.sel[0] = 1'b1;
            a_arr[0]   = 12'h011;
            d_arr[0]   = 13'h00BB;
         end
      end
      checkOutput("cap_done", {31'b0, done}, 32'd1);
      @(negedge clk);
      checkOutput("cap_count", glog.size(), 32'd9);
      for (int i = 0; i < 9; i++)
         checkOutput("cap_order", (i < glog.size()) ? glog[i] : -1, (i < 8) ? 1 : 0);

      $display("[TB] reset in the middle of a read");
      doReset();
      @(negedge clk);
      bus.req[2] = 1'b1;
      a_arr[2]   = 12'h040;
      @(negedge clk);
      checkOutput("midrd_gnt", {29'b0, bus.gnt}, 32'h4);
      checkOutput("midrd_crd", {31'b0, bus.crd}, 32'd1);
      clearInputs();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midrd_clear", {bus.gnt, bus.rvalid, bus.cwr, bus.crd, bus.csel} == '0 ? 32'd0 : 32'd1, 32'd0);
      checkOutput("midrd_addr", {20'b0, bus.caddr_rd}, 32'd0);
      reset   = 1'b1;
      rv_snap = rv_count;
      repeat (6) @(negedge clk);
      checkOutput("midrd_no_rvalid", rv_count - rv_snap, 32'd0);

      $display("[TB] idle for 50 cycles");
      glog.delete();
      idle_bad = 0;
      repeat (50) begin
         @(negedge clk);
         if ((|bus.gnt) || (|bus.rvalid) || bus.cwr || bus.crd) idle_bad++;
      end
      checkOutput("idle_activity", idle_bad, 32'd0);
      checkOutput("idle_grants", glog.size(), 32'd0);

      checkOutput("sb_drain", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
